// File: rtl/ripple_cnt_ctrl_pkg.sv
`default_nettype none
// ============================================================
// ripple_cnt_pkg : shared types for the ripple counter sequencer
// Rev 1.0
// ============================================================
package ripple_cnt_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_RST_CLR = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CLR     = 3'd2,
    ST_PULSE_H = 3'd3,
    ST_PULSE_L = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_CHECK   = 3'd6
  } ripple_cnt_state_e;

  typedef enum logic {
    OP_INCR  = 1'b0,
    OP_CLEAR = 1'b1
  } ripple_cnt_op_e;

endpackage
`default_nettype wire

// File: rtl/ripple_cnt_ctrl_if.sv
`default_nettype none
// ============================================================
// ripple_cnt_ctrl_if : command handshake (valid/ready, op, count)
// Rev 1.0
// ============================================================
interface ripple_cnt_ctrl_if;
  import ripple_cnt_pkg::*;

  logic           req_valid;
  logic           req_ready;
  ripple_cnt_op_e req_op;
  logic [7:0]     req_num;

  modport master (output req_valid, output req_op, output req_num, input req_ready);
  modport slave  (input req_valid, input req_op, input req_num, output req_ready);

endinterface
`default_nettype wire

// File: rtl/ripple_cnt_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================
// sync_2ff : two-flop synchronizer, async active-low reset to 0
// Rev 1.0
// ============================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ripple_cnt_ctrl.sv
`default_nettype none
// ============================================================
// ripple_cnt_ctrl : strobe sequencer and checker for a mod-N ripple counter
// Rev 1.0
// ============================================================
module ripple_cnt_ctrl
  import ripple_cnt_pkg::*;
#(
  parameter int N        = 3,
  parameter int PULSE_HI = 2,
  parameter int PULSE_LO = 2,
  parameter int SETTLE   = 3,
  localparam int W       = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ripple_cnt_ctrl_if.slave       req,
  output logic                   incr_o,
  output logic                   clear_o,
  input  logic [W-1:0]           cnt_i,
  output logic [W-1:0]           count_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [7:0]   c_HI_LAST     = 8'(PULSE_HI - 1);
  localparam logic [7:0]   c_LO_LAST     = 8'(PULSE_LO - 1);
  localparam logic [7:0]   c_SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [W-1:0] c_SHADOW_MAX  = W'(N - 1);

  generate
    if (SETTLE < SYNC_STAGES + 1 || SETTLE > 255 || N < 2 ||
        PULSE_HI < 1 || PULSE_HI > 255 || PULSE_LO < 1 || PULSE_LO > 255) begin : g_param_check
      $error("ripple_cnt_ctrl: illegal parameter set");
    end
  endgenerate

  ripple_cnt_state_e r_state;
  ripple_cnt_state_e w_next;
  logic [7:0]        r_timer;
  logic [7:0]        r_remaining;
  logic [W-1:0]      r_shadow;
  logic [W-1:0]      r_count;
  logic              r_err;
  logic              r_incr;
  logic              r_clear;
  logic              w_timer_last;
  logic              w_accept;
  logic [W-1:0]      w_sync;

  sync_2ff #(.WIDTH(W)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (cnt_i),
    .o_q    (w_sync)
  );

  assign w_accept = req.req_valid & (r_state == ST_IDLE);

  always_comb begin
    w_timer_last = 1'b0;
    case (r_state)
      ST_RST_CLR, ST_CLR, ST_PULSE_H: w_timer_last = (r_timer == c_HI_LAST);
      ST_PULSE_L:                     w_timer_last = (r_timer == c_LO_LAST);
      ST_SETTLE:                      w_timer_last = (r_timer == c_SETTLE_LAST);
      default:                        w_timer_last = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST_CLR: if (w_timer_last) w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_accept) begin
          if (req.req_op == OP_CLEAR)  w_next = ST_CLR;
          else if (req.req_num != '0)  w_next = ST_PULSE_H;
          else                         w_next = ST_SETTLE;
        end
      end
      ST_CLR:     if (w_timer_last) w_next = ST_SETTLE;
      ST_PULSE_H: if (w_timer_last) w_next = ST_PULSE_L;
      // r_remaining still counts the pulse just finished
      ST_PULSE_L: if (w_timer_last) w_next = (r_remaining > 8'd1) ? ST_PULSE_H : ST_SETTLE;
      ST_SETTLE:  if (w_timer_last) w_next = ST_CHECK;
      ST_CHECK:   w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so the counter sees clean edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RST_CLR;
      r_timer     <= 8'd0;
      r_remaining <= 8'd0;
      r_shadow    <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_incr      <= 1'b0;
      r_clear     <= 1'b1;
    end else begin
      r_state <= w_next;
      r_incr  <= (w_next == ST_PULSE_H);
      r_clear <= (w_next == ST_CLR) || (w_next == ST_RST_CLR);

      if (w_next != r_state || r_state == ST_IDLE) r_timer <= 8'd0;
      else                                         r_timer <= r_timer + 8'd1;

      if (w_accept) r_remaining <= req.req_num;
      else if (r_state == ST_PULSE_L && w_timer_last) r_remaining <= r_remaining - 8'd1;

      if (w_accept && req.req_op == OP_CLEAR) begin
        r_shadow <= '0;
        r_err    <= 1'b0;
      end else if (w_next == ST_PULSE_H && r_state != ST_PULSE_H) begin
        r_shadow <= (r_shadow == c_SHADOW_MAX) ? '0 : r_shadow + 1'b1;
      end else if (r_state == ST_CHECK) begin
        r_err   <= r_err | (w_sync != r_shadow);
      end

      if (r_state == ST_CHECK) r_count <= w_sync;
    end
  end

  assign req.req_ready = (r_state == ST_IDLE);
  assign done_o        = (r_state == ST_CHECK);
  assign incr_o        = r_incr;
  assign clear_o       = r_clear;
  assign count_o       = r_count;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ripple_cnt_ctrl.sv
`default_nettype none
// ============================================================
// tb_ripple_cnt_ctrl : bench with a mod-3 ripple counter model
// Rev 1.0
// ============================================================
module tb_ripple_cnt_ctrl;
  import ripple_cnt_pkg::*;

  localparam int N = 3, PH = 2, PL = 2, ST = 3;

  typedef struct {
    ripple_cnt_op_e op;
    logic [7:0]     num;
    logic           fen;
    logic [1:0]     fval;
    int             lat;
    logic [1:0]     exp_cnt;
    logic           exp_err;
  } vec_t;

  typedef struct {
    int         done_cyc;
    logic [1:0] cnt;
    logic       err;
    int         edges;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       incr, clear, done, err;
  logic [1:0] cnt_in, count;
  logic [1:0] model_cnt = 2'd0;
  logic       force_en = 1'b0;
  logic [1:0] force_val = 2'd0;
  int         cyc = 0;
  int         incr_edges = 0;
  int         hi_run = 0;
  logic       bad_pulse = 1'b0;
  logic       overlap = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         last_done = 0;
  exp_t       sb[$];
  exp_t       cur;
  vec_t       vecs[9];

  always #5 clk = ~clk;

  ripple_cnt_ctrl_if u_if ();

  ripple_cnt_ctrl #(.N(N), .PULSE_HI(PH), .PULSE_LO(PL), .SETTLE(ST)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req     (u_if.slave),
    .incr_o  (incr),
    .clear_o (clear),
    .cnt_i   (cnt_in),
    .count_o (count),
    .done_o  (done),
    .err_o   (err)
  );

  // Asynchronous mod-3 counter model clocked by the strobes
  always @(posedge incr or posedge clear) begin
    if (clear) model_cnt <= 2'd0;
    else       model_cnt <= (model_cnt == 2'd2) ? 2'd0 : model_cnt + 2'd1;
  end
  assign cnt_in = force_en ? force_val : model_cnt;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge incr) incr_edges = incr_edges + 1;

  always @(negedge clk) begin
    if (incr && clear) overlap = 1'b1;
    if (incr) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0 && hi_run != PH) bad_pulse = 1'b1;
      hi_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: pops on done_o, checks results one cycle later
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          cur = sb.pop_front();
          check("done_cycle", cyc, cur.done_cyc);
          check("incr_edges", incr_edges, cur.edges);
          @(negedge clk);
          check("count_o", 32'(count), 32'(cur.cnt));
          check("err_o", 32'(err), 32'(cur.err));
        end
      end
    end
  end

  task automatic issue(input ripple_cnt_op_e op, input logic [7:0] num, input logic fen,
                       input logic [1:0] fval, input int lat, input logic [1:0] ecnt,
                       input logic eerr, input bit chk_b2b);
    int   waited = 0;
    exp_t e;
    u_if.req_valid = 1'b1;
    u_if.req_op    = op;
    u_if.req_num   = num;
    while (u_if.req_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no ready in %0d cycles, expected ready", waited);
      u_if.req_valid = 1'b0;
      return;
    end
    if (chk_b2b) check("accept_after_done", cyc, last_done + 1);
    force_en   = fen;
    force_val  = fval;
    incr_edges = 0;
    e.done_cyc = cyc + lat;
    e.cnt      = ecnt;
    e.err      = eerr;
    e.edges    = (op == OP_INCR) ? int'(num) : 0;
    sb.push_back(e);
    last_done = e.done_cyc;
    @(negedge clk);
    u_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic release_and_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_clear", 32'(clear), 32'd1);
    check("rel1_ready", 32'(u_if.req_ready), 32'd0);
    @(negedge clk);
    check("rel2_clear", 32'(clear), 32'd0);
    check("rel2_ready", 32'(u_if.req_ready), 32'd1);
  endtask

  initial begin
    int w;
    u_if.req_valid = 1'b0;
    u_if.req_op    = OP_INCR;
    u_if.req_num   = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    //            op        k      force  fval  lat cnt   err
    vecs[0] = '{OP_INCR,  8'd4, 1'b0, 2'd0, 20, 2'd1, 1'b0};
    vecs[1] = '{OP_CLEAR, 8'd0, 1'b0, 2'd0,  6, 2'd0, 1'b0};
    vecs[2] = '{OP_INCR,  8'd2, 1'b0, 2'd0, 12, 2'd2, 1'b0};
    vecs[3] = '{OP_INCR,  8'd1, 1'b0, 2'd0,  8, 2'd0, 1'b0};
    vecs[4] = '{OP_CLEAR, 8'd9, 1'b1, 2'd2,  6, 2'd2, 1'b1};
    vecs[5] = '{OP_INCR,  8'd0, 1'b1, 2'd2,  4, 2'd2, 1'b1};
    vecs[6] = '{OP_CLEAR, 8'd0, 1'b0, 2'd0,  6, 2'd0, 1'b0};
    vecs[7] = '{OP_INCR,  8'd5, 1'b0, 2'd0, 24, 2'd2, 1'b0};
    vecs[8] = '{OP_INCR,  8'd0, 1'b0, 2'd0,  4, 2'd2, 1'b0};

    repeat (5) begin
      @(negedge clk);
      check("rst_clear", 32'(clear), 32'd1);
      check("rst_incr", 32'(incr), 32'd0);
      check("rst_ready", 32'(u_if.req_ready), 32'd0);
    end
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    release_and_check();

    // Back-to-back: each command's valid is held while the previous one runs
    for (int i = 0; i < 9; i++)
      issue(vecs[i].op, vecs[i].num, vecs[i].fen, vecs[i].fval, vecs[i].lat,
            vecs[i].exp_cnt, vecs[i].exp_err, i > 0);
    drain();

    // Reset in the middle of the third pulse of INCR k=5
    issue(OP_INCR, 8'd5, 1'b0, 2'd0, 24, 2'd1, 1'b0, 1'b0);
    w = 0;
    while (incr_edges < 3 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("midop_third_pulse", incr_edges, 3);
    rst_n = 1'b0;
    #1;
    check("midop_incr", 32'(incr), 32'd0);
    check("midop_clear", 32'(clear), 32'd1);
    check("midop_ready", 32'(u_if.req_ready), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    release_and_check();
    issue(OP_INCR, 8'd1, 1'b0, 2'd0, 8, 2'd1, 1'b0, 1'b0);
    drain();

    check("strobe_overlap", 32'(overlap), 32'd0);
    check("incr_pulse_width", 32'(bad_pulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
